// File: rtl/control_axil_slave.sv
// AXI4-Lite slave: 4 RW control registers (0x00-0x0C) and 4 RO status words (0x10-0x1C).
// Latency: ready 1 cycle after AW+W (or AR) valid; B (or R) valid one cycle later.
// Backpressure: bvalid/rvalid hold until bready/rready; no new request accepted meanwhile.
module control_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
    output logic [3:0]                        wr_pulse,
    input  logic [4*C_S_AXI_DATA_WIDTH-1:0]   status_in
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic              awready_q, awready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [3:0]        wr_pulse_q, wr_pulse_d;
    logic [DW-1:0]     regs_q [4];
    logic [DW-1:0]     regs_d [4];
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic              w_hs, r_hs;
    logic [2:0]        w_idx, r_idx;
    logic              unused_ok;

    // Word index only; byte offset and protection bits carry no meaning here.
    assign w_idx     = s00_axi_awaddr[4:2];
    assign r_idx     = s00_axi_araddr[4:2];
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // AW and W share one ready, so both are consumed in the same cycle.
    assign w_hs = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign r_hs = arready_q & s00_axi_arvalid;

    // Write channel: accept AW+W together, apply byte lanes, then hold the response.
    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 4'b0000;
        for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
        case (w_state_q)
            W_IDLE: begin
                if (w_hs) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    if (!w_idx[2]) begin
                        bresp_d = RESP_OKAY;
                        wr_pulse_d[w_idx[1:0]] = 1'b1;
                        for (int k = 0; k < NB; k++) begin
                            if (s00_axi_wstrb[k]) regs_d[w_idx[1:0]][8*k +: 8] = s00_axi_wdata[8*k +: 8];
                        end
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else if (!awready_q && s00_axi_awvalid && s00_axi_wvalid) begin
                    awready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel: accept AR, capture the addressed word at the handshake, hold until rready.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (r_hs) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_idx[2] ? status_in[DW*r_idx[1:0] +: DW] : regs_q[r_idx[1:0]];
                end else if (!arready_q && s00_axi_arvalid) begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and register file; reset discards any in-flight response.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= 4'b0000;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;
    assign wr_pulse        = wr_pulse_q;
    assign ctrl_out        = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

// File: tb/tb_control_axil_slave.sv
// Directed bench for control_axil_slave: reset, RW/RO access, byte strobes, stalls, mid-flight reset.
// Inputs driven and outputs sampled on the falling edge.
// Responses are accepted immediately except where a stall is being exercised.
module tb_control_axil_slave;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, arvalid, arready, rvalid, rready;
    logic [127:0] ctrl_out, status_in;
    logic [3:0]   wr_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_axil_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .ctrl_out        (ctrl_out),
        .wr_pulse        (wr_pulse),
        .status_in       (status_in)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the response retires.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int lat, output logic bv, output logic [1:0] resp,
                             output logic [3:0] p0, output logic [3:0] p1);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(awready && wready) && lat < 20);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        bv = bvalid; resp = bresp; p0 = wr_pulse;
        @(negedge clk);
        p1 = wr_pulse;
    endtask

    task automatic axi_read(input logic [4:0] a, output int lat, output logic rv,
                            output logic [31:0] d, output logic [1:0] resp);
        araddr = a; arvalid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!arready && lat < 20);
        @(negedge clk);
        arvalid = 1'b0;
        rv = rvalid; d = rdata; resp = rresp;
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic        v;
        logic [1:0]  resp;
        logic [3:0]  p0, p1;
        logic [31:0] d;

        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1; status_in = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 3'b000);
        chk("rst_valid", {bvalid, rvalid}, 2'b00);
        chk("rst_pulse", wr_pulse, 4'h0);
        chk("rst_resp", {bresp, rresp}, 4'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ctrl", ctrl_out, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            axi_read(5'(4 * i), lat, v, d, resp);
            chk($sformatf("rd0_lat_%0d", i), lat, 1);
            chk($sformatf("rd0_%0d", i), {v, resp, d}, {1'b1, 2'b00, 32'h0});
        end

        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, lat, v, resp, p0, p1);
            chk($sformatf("wr_lat_%0d", i), lat, 1);
            chk($sformatf("wr_b_%0d", i), {v, resp}, {1'b1, 2'b00});
            chk($sformatf("wr_pulse_%0d", i), {p0, p1}, {4'(1 << i), 4'h0});
        end
        chk("ctrl_1234", ctrl_out, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), lat, v, d, resp);
            chk($sformatf("rdback_%0d", i), {v, resp, d}, {1'b1, 2'b00, 32'(i + 1)});
        end

        axi_write(5'h00, 32'hAABBCCDD, 4'hF, lat, v, resp, p0, p1);
        axi_write(5'h00, 32'h11223344, 4'h5, lat, v, resp, p0, p1);
        chk("strb_pulse", {p0, p1}, {4'b0001, 4'h0});
        axi_read(5'h00, lat, v, d, resp);
        chk("strb_rd", d, 32'hAA22CC44);

        status_in = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
        axi_write(5'h10, 32'h12345678, 4'hF, lat, v, resp, p0, p1);
        chk("ro_bresp", {v, resp}, {1'b1, 2'b10});
        chk("ro_pulse", {p0, p1}, 8'h00);
        chk("ro_ctrl", ctrl_out, 128'h00000004_00000003_00000002_AA22CC44);
        axi_read(5'h10, lat, v, d, resp);
        chk("ro_rd", {v, resp, d}, {1'b1, 2'b00, 32'hDEADBEEF});

        // AW leads W by three cycles, then B is stalled while a second write waits.
        bready = 1'b0;
        awaddr = 5'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("aw_only_%0d", i), {awready, wready}, 2'b00);
        end
        wvalid = 1'b1;
        @(negedge clk);
        chk("aw_w_together", {awready, wready}, 2'b11);
        @(negedge clk);
        chk("stall_b_0", {bvalid, wr_pulse}, {1'b1, 4'b0010});
        awaddr = 5'h08; wdata = 32'h66;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_b_%0d", i), {bvalid, awready, wready}, 3'b100);
        end
        bready = 1'b1;
        @(negedge clk);
        chk("stall_release", {bvalid, awready}, 2'b00);
        @(negedge clk);
        chk("second_accept", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("second_b", {bvalid, bresp, wr_pulse}, {1'b1, 2'b00, 4'b0100});
        @(negedge clk);
        chk("stall_ctrl", ctrl_out, 128'h00000004_00000066_00000055_AA22CC44);

        // Reset while both a B and an R response are pending.
        bready = 1'b0; rready = 1'b0; status_in = '0;
        awaddr = 5'h00; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h0C; arvalid = 1'b1;
        @(negedge clk);
        chk("pre_rst_ready", {awready, arready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("pre_rst_valid", {bvalid, rvalid, rdata}, {2'b11, 32'h4});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {bvalid, rvalid}, 2'b00);
        chk("mid_rst_ctrl", ctrl_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            axi_read(5'(4 * i), lat, v, d, resp);
            chk($sformatf("post_rst_rd_%0d", i), {v, d}, {1'b1, 32'h0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_axil_slave.md
# control_axil_slave

AXI4-Lite responder for the controlIP block. It exposes four 32-bit read/write control registers and four 32-bit read-only status registers to the PS/AXI master. The registers drive NPU control outputs, and each write emits a per-register commit pulse. It answers the same transaction sequence the controlIP bench issues: single-beat INCR writes and reads at 4-byte stride from offset 0x00.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; covers 8 words.
- s00_axi_aclk  in  1  single clock; all logic rises on this edge.
- s00_axi_aresetn  in  1  reset, asynchronous assert, active-low; release is synchronised to s00_axi_aclk by the integrating design.
- s00_axi_awaddr  in  5  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write data handshake.
- s00_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s00_axi_bvalid / s00_axi_bready  out / in  1  write response handshake.
- s00_axi_araddr  in  5  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response; always 2'b00.
- s00_axi_rvalid / s00_axi_rready  out / in  1  read data handshake.
- ctrl_out  out  128  {reg3, reg2, reg1, reg0}.
- wr_pulse  out  4  one-cycle commit strobe, one bit per control register.
- status_in  in  128  {st3, st2, st1, st0}; sampled at read handshake.

## Operation
- Word index is addr[4:2].
  - Indices 0–3 map to RW control registers reg0–reg3.
  - Indices 4–7 map to status words st0–st3, which are read-only.
  - addr[1:0] is ignored.
- Write FSM has two states, W_IDLE and W_RESP.
  - In W_IDLE, when awvalid and wvalid are both high, awready and wready are asserted together for exactly one cycle. Both are registered.
  - Neither awready nor wready is asserted while only one of awvalid/wvalid is high.
  - Handshake cycle, index 0–3: byte lanes with wstrb[k]=1 update reg[idx][8k+7:8k]; other lanes keep their value. bresp=OKAY.
  - Handshake cycle, index 4–7: no register changes. bresp=SLVERR.
  - After the handshake, the FSM moves to W_RESP with bvalid=1. It holds bvalid and bresp until bready=1, then returns to W_IDLE.
  - No new AW/W is accepted while in W_RESP.
- wr_pulse[idx]=1 for the single cycle after a write handshake to index 0–3. This holds even when wstrb=0. No pulse is generated for indices 4–7.
- Read FSM has two states, R_IDLE and R_DATA.
  - In R_IDLE, arvalid=1 causes arready to be asserted for one registered cycle.
  - At the arready handshake, rdata latches the addressed word: reg[idx] for 0–3, status_in slice for 4–7.
  - The FSM then enters R_DATA with rvalid=1, rresp=OKAY.
  - rdata/rvalid are held stable until rready=1, then the FSM returns to R_IDLE.
- Read and write channels are fully independent and may be active in the same cycle.
- A read handshake in the same cycle as a write handshake to the same index returns the pre-write value.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid, wr_pulse = 0. bresp, rresp, rdata = 0. reg0–reg3 = 0, so ctrl_out = 0.
- Reset assertion clears all of the above asynchronously, mid-transaction included. Pending B/R responses are discarded. The FSMs return to W_IDLE/R_IDLE.
- Write latency, with AW and W valid sampled high at edge 0:
  - awready=wready=1 during cycle 1.
  - Register update and bvalid=1 from cycle 2.
  - wr_pulse high during cycle 2.
  - ctrl_out shows the new value from cycle 2.
- Read latency, with arvalid sampled high at edge 0: arready=1 during cycle 1; rvalid=1 with valid rdata from cycle 2.
- Throughput with bready/rready tied high: one write every 3 cycles and one read every 3 cycles, concurrently.
- If bready/rready are held low for N cycles, the response stalls N cycles. Outputs stay unchanged during the stall.

## Test plan
- Reset, then read indices 0–7 with status_in=0 → all rdata=0x00000000, rresp=OKAY. Check every output is 0 during reset.
- Write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C with wstrb=0xF, then read them back.
  - Reads return 0x1–0x4.
  - bresp=OKAY each time.
  - wr_pulse sequence is 0001, 0010, 0100, 1000, one cycle each.
  - ctrl_out=0x00000004_00000003_00000002_00000001.
- Write 0xAABBCCDD to 0x00, then write 0x11223344 with wstrb=0x5 → read returns 0xAA22CC44.
- Write to 0x10 with status_in st0=0xDEADBEEF → bresp=SLVERR, no wr_pulse, ctrl_out unchanged. A read of 0x10 returns 0xDEADBEEF.
- Present awvalid 3 cycles before wvalid; hold bready low 5 cycles after bvalid.
  - awready/wready rise together only once wvalid is seen.
  - bvalid stays high for 5 cycles.
  - A second write offered during the stall is not accepted until bready is seen.
- Assert s00_axi_aresetn low while rvalid=1 and bvalid=1 → both drop immediately and all registers read 0 after release.
